// File: rtl/gx_rst_pkg.sv
// Shared types and default timing for the GX transceiver reset sequencer.
package gx_rst_pkg;

  typedef enum logic [1:0] {TX_PD, TX_LOCK, TX_ANA, TX_READY} tx_state_t;
  typedef enum logic [1:0] {RX_ANA, RX_LTD, RX_READY} rx_state_t;

  localparam int T_PLL_PD_DEF = 50;
  localparam int T_TX_DIG_DEF = 100;
  localparam int T_RX_ANA_DEF = 50;
  localparam int T_RX_LTD_DEF = 200;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync2ff.sv
// Per-bit two-flop synchronizer for asynchronous status inputs.
module sync2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gx_rst_seq.sv
// GX transceiver reset sequencer: independent TX and RX bring-up FSMs in the clk_50m domain.
//   state    | meaning
//   TX_PD    | PLL held in powerdown for T_PLL_PD cycles
//   TX_LOCK  | PLL running, waiting for lock and calibration idle
//   TX_ANA   | TX PMA released, waiting T_TX_DIG before PCS release
//   TX_READY | TX path usable
//   RX_ANA   | RX PMA reset for T_RX_ANA cycles and until RX cal idle
//   RX_LTD   | waiting for T_RX_LTD continuous cycles of lock-to-data
//   RX_READY | RX path usable
module gx_rst_seq
  import gx_rst_pkg::*;
#(
  parameter int T_PLL_PD = T_PLL_PD_DEF,
  parameter int T_TX_DIG = T_TX_DIG_DEF,
  parameter int T_RX_ANA = T_RX_ANA_DEF,
  parameter int T_RX_LTD = T_RX_LTD_DEF
) (
  input  logic clk,
  input  logic nreset,
  input  logic pll_locked_i,
  input  logic tx_cal_busy_i,
  input  logic rx_cal_busy_i,
  input  logic rx_is_lockedtodata_i,
  output logic pll_powerdown_o,
  output logic tx_analogreset_o,
  output logic tx_digitalreset_o,
  output logic tx_ready_o,
  output logic rx_analogreset_o,
  output logic rx_digitalreset_o,
  output logic rx_ready_o
);

  localparam int CW = $clog2(max4(T_PLL_PD, T_TX_DIG, T_RX_ANA, T_RX_LTD) + 1);
  localparam logic [CW-1:0] PD_DONE  = CW'(T_PLL_PD - 1);
  localparam logic [CW-1:0] DIG_DONE = CW'(T_TX_DIG - 1);
  localparam logic [CW-1:0] ANA_DONE = CW'(T_RX_ANA - 1);
  localparam logic [CW-1:0] LTD_DONE = CW'(T_RX_LTD - 1);

  logic [3:0] sync_q;
  logic       locked_s, tx_busy_s, rx_busy_s, ltd_s;

  sync2ff #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (nreset),
    .d     ({pll_locked_i, tx_cal_busy_i, rx_cal_busy_i, rx_is_lockedtodata_i}),
    .q     (sync_q)
  );

  assign {locked_s, tx_busy_s, rx_busy_s, ltd_s} = sync_q;

  tx_state_t         tx_state, tx_nxt;
  rx_state_t         rx_state, rx_nxt;
  logic [CW-1:0]     tx_cnt, tx_cnt_nxt, rx_cnt, rx_cnt_nxt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_state          <= TX_PD;
      rx_state          <= RX_ANA;
      tx_cnt            <= '0;
      rx_cnt            <= '0;
      pll_powerdown_o   <= 1'b1;
      tx_analogreset_o  <= 1'b1;
      tx_digitalreset_o <= 1'b1;
      tx_ready_o        <= 1'b0;
      rx_analogreset_o  <= 1'b1;
      rx_digitalreset_o <= 1'b1;
      rx_ready_o        <= 1'b0;
    end else begin
      tx_state          <= tx_nxt;
      rx_state          <= rx_nxt;
      tx_cnt            <= tx_cnt_nxt;
      rx_cnt            <= rx_cnt_nxt;
      pll_powerdown_o   <= (tx_nxt == TX_PD);
      tx_analogreset_o  <= (tx_nxt == TX_PD) || (tx_nxt == TX_LOCK);
      tx_digitalreset_o <= (tx_nxt != TX_READY);
      tx_ready_o        <= (tx_nxt == TX_READY);
      rx_analogreset_o  <= (rx_nxt == RX_ANA);
      rx_digitalreset_o <= (rx_nxt != RX_READY);
      rx_ready_o        <= (rx_nxt == RX_READY);
    end
  end

  // Loss of lock is checked before counter done so it always wins.
  always_comb begin
    tx_nxt     = tx_state;
    tx_cnt_nxt = tx_cnt;
    case (tx_state)
      TX_PD: begin
        if (tx_cnt == PD_DONE) begin
          tx_nxt     = TX_LOCK;
          tx_cnt_nxt = '0;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      TX_LOCK: begin
        tx_cnt_nxt = '0;
        if (locked_s && !tx_busy_s) tx_nxt = TX_ANA;
      end
      TX_ANA: begin
        if (!locked_s) begin
          tx_nxt     = TX_LOCK;
          tx_cnt_nxt = '0;
        end else if (tx_cnt == DIG_DONE) begin
          tx_nxt     = TX_READY;
          tx_cnt_nxt = '0;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      TX_READY: begin
        tx_cnt_nxt = '0;
        if (!locked_s) tx_nxt = TX_LOCK;
      end
      default: begin
        tx_nxt     = TX_PD;
        tx_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    rx_nxt     = rx_state;
    rx_cnt_nxt = rx_cnt;
    case (rx_state)
      RX_ANA: begin
        if (rx_cnt == ANA_DONE) begin
          if (!rx_busy_s) begin
            rx_nxt     = RX_LTD;
            rx_cnt_nxt = '0;
          end
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      RX_LTD: begin
        if (rx_busy_s) begin
          rx_nxt     = RX_ANA;
          rx_cnt_nxt = '0;
        end else if (!ltd_s) begin
          rx_cnt_nxt = '0;
        end else if (rx_cnt == LTD_DONE) begin
          rx_nxt     = RX_READY;
          rx_cnt_nxt = '0;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      RX_READY: begin
        rx_cnt_nxt = '0;
        if (rx_busy_s) rx_nxt = RX_ANA;
        else if (!ltd_s) rx_nxt = RX_LTD;
      end
      default: begin
        rx_nxt     = RX_ANA;
        rx_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gx_rst_seq.sv
// Directed bench for gx_rst_seq with short timing; the PLL model reports lock only once powerdown is released.
module tb_gx_rst_seq;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic pll_locked_i = 1'b0;
  logic tx_cal_busy_i = 1'b0;
  logic rx_cal_busy_i = 1'b0;
  logic rx_is_lockedtodata_i = 1'b1;
  logic pll_powerdown_o, tx_analogreset_o, tx_digitalreset_o, tx_ready_o;
  logic rx_analogreset_o, rx_digitalreset_o, rx_ready_o;

  logic pll_ok = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   b;

  gx_rst_seq #(
    .T_PLL_PD (4),
    .T_TX_DIG (8),
    .T_RX_ANA (4),
    .T_RX_LTD (16)
  ) dut (
    .clk                  (clk),
    .nreset               (nreset),
    .pll_locked_i         (pll_locked_i),
    .tx_cal_busy_i        (tx_cal_busy_i),
    .rx_cal_busy_i        (rx_cal_busy_i),
    .rx_is_lockedtodata_i (rx_is_lockedtodata_i),
    .pll_powerdown_o      (pll_powerdown_o),
    .tx_analogreset_o     (tx_analogreset_o),
    .tx_digitalreset_o    (tx_digitalreset_o),
    .tx_ready_o           (tx_ready_o),
    .rx_analogreset_o     (rx_analogreset_o),
    .rx_digitalreset_o    (rx_digitalreset_o),
    .rx_ready_o           (rx_ready_o)
  );

  always #5 clk = ~clk;

  // PLL lock follows powerdown release, half a cycle late.
  initial begin
    forever begin
      @(negedge clk);
      pll_locked_i = pll_ok && !pll_powerdown_o;
    end
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    nreset = 1'b1;
    cyc = 0;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_pd"},      pll_powerdown_o,   1'b1);
    chk({tag, "_tx_ana"},  tx_analogreset_o,  1'b1);
    chk({tag, "_tx_dig"},  tx_digitalreset_o, 1'b1);
    chk({tag, "_tx_rdy"},  tx_ready_o,        1'b0);
    chk({tag, "_rx_ana"},  rx_analogreset_o,  1'b1);
    chk({tag, "_rx_dig"},  rx_digitalreset_o, 1'b1);
    chk({tag, "_rx_rdy"},  rx_ready_o,        1'b0);
  endtask

  initial begin
    // clean bring-up
    #23;
    chk_rst_vals("rst");
    release_rst();
    wait_cyc(3);
    chk("up_pd_c3", pll_powerdown_o, 1'b1);
    chk("up_rxana_c3", rx_analogreset_o, 1'b1);
    wait_cyc(4);
    chk("up_pd_c4", pll_powerdown_o, 1'b0);
    chk("up_txana_c4", tx_analogreset_o, 1'b1);
    chk("up_rxana_c4", rx_analogreset_o, 1'b0);
    wait_cyc(6);
    chk("up_txana_c6", tx_analogreset_o, 1'b1);
    wait_cyc(7);
    chk("up_txana_c7", tx_analogreset_o, 1'b0);
    chk("up_txdig_c7", tx_digitalreset_o, 1'b1);
    wait_cyc(14);
    chk("up_txrdy_c14", tx_ready_o, 1'b0);
    wait_cyc(15);
    chk("up_txrdy_c15", tx_ready_o, 1'b1);
    chk("up_txdig_c15", tx_digitalreset_o, 1'b0);
    wait_cyc(19);
    chk("up_rxrdy_c19", rx_ready_o, 1'b0);
    wait_cyc(20);
    chk("up_rxrdy_c20", rx_ready_o, 1'b1);
    chk("up_rxdig_c20", rx_digitalreset_o, 1'b0);
    wait_cyc(25);

    // one-cycle PLL lock loss in TX_READY
    b = cyc;
    pll_ok = 1'b0;
    wait_cyc(b + 1);
    pll_ok = 1'b1;
    wait_cyc(b + 2);
    chk("pll_txrdy_b2", tx_ready_o, 1'b1);
    wait_cyc(b + 3);
    chk("pll_txrdy_b3", tx_ready_o, 1'b0);
    chk("pll_txana_b3", tx_analogreset_o, 1'b1);
    chk("pll_txdig_b3", tx_digitalreset_o, 1'b1);
    chk("pll_pd_b3", pll_powerdown_o, 1'b0);
    chk("pll_rxrdy_b3", rx_ready_o, 1'b1);
    wait_cyc(b + 4);
    chk("pll_txana_b4", tx_analogreset_o, 1'b0);
    wait_cyc(b + 11);
    chk("pll_txrdy_b11", tx_ready_o, 1'b0);
    wait_cyc(b + 12);
    chk("pll_txrdy_b12", tx_ready_o, 1'b1);
    wait_cyc(b + 15);

    // RX calibration rerun from RX_READY, busy held 10 cycles
    b = cyc;
    rx_cal_busy_i = 1'b1;
    wait_cyc(b + 2);
    chk("rxcal_rxrdy_m2", rx_ready_o, 1'b1);
    wait_cyc(b + 3);
    chk("rxcal_rxrdy_m3", rx_ready_o, 1'b0);
    chk("rxcal_rxana_m3", rx_analogreset_o, 1'b1);
    wait_cyc(b + 10);
    rx_cal_busy_i = 1'b0;
    wait_cyc(b + 12);
    chk("rxcal_rxana_m12", rx_analogreset_o, 1'b1);
    chk("rxcal_txrdy_m12", tx_ready_o, 1'b1);
    wait_cyc(b + 13);
    chk("rxcal_rxana_m13", rx_analogreset_o, 1'b0);
    chk("rxcal_rxdig_m13", rx_digitalreset_o, 1'b1);

    // CDR glitch at LTD count 10
    b = cyc;
    wait_cyc(b + 10);
    rx_is_lockedtodata_i = 1'b0;
    wait_cyc(b + 11);
    rx_is_lockedtodata_i = 1'b1;
    wait_cyc(b + 16);
    chk("ltd_rxrdy_l16", rx_ready_o, 1'b0);
    wait_cyc(b + 28);
    chk("ltd_rxrdy_l28", rx_ready_o, 1'b0);
    chk("ltd_rxdig_l28", rx_digitalreset_o, 1'b1);
    wait_cyc(b + 29);
    chk("ltd_rxrdy_l29", rx_ready_o, 1'b1);
    chk("ltd_txrdy_l29", tx_ready_o, 1'b1);

    // async reset mid-sequence, then bring-up with TX cal stall
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk_rst_vals("arst_rdy");
    release_rst();
    wait_cyc(10);
    chk("mid_txana_c10", tx_analogreset_o, 1'b0);
    chk("mid_txrdy_c10", tx_ready_o, 1'b0);
    chk("mid_rxana_c10", rx_analogreset_o, 1'b0);
    chk("mid_rxrdy_c10", rx_ready_o, 1'b0);
    #3;
    nreset = 1'b0;
    #1;
    chk_rst_vals("arst_mid");
    tx_cal_busy_i = 1'b1;
    repeat (5) @(negedge clk);
    release_rst();
    wait_cyc(3);
    chk("stall_pd_c3", pll_powerdown_o, 1'b1);
    wait_cyc(4);
    chk("stall_pd_c4", pll_powerdown_o, 1'b0);
    wait_cyc(20);
    chk("stall_txana_c20", tx_analogreset_o, 1'b1);
    chk("stall_txrdy_c20", tx_ready_o, 1'b0);
    chk("stall_rxrdy_c20", rx_ready_o, 1'b1);
    wait_cyc(46);
    chk("stall_txana_c46", tx_analogreset_o, 1'b1);
    tx_cal_busy_i = 1'b0;
    wait_cyc(48);
    chk("stall_txana_c48", tx_analogreset_o, 1'b1);
    wait_cyc(49);
    chk("stall_txana_c49", tx_analogreset_o, 1'b0);
    wait_cyc(56);
    chk("stall_txrdy_c56", tx_ready_o, 1'b0);
    wait_cyc(57);
    chk("stall_txrdy_c57", tx_ready_o, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
